// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared widths, requester identifiers and sprite-address packing for the
// two-player sprite ROM arbiter.
package sprite_rom_arbiter_pkg;

  localparam int unsigned POSE_W = 2;
  localparam int unsigned DIM_W  = 6;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = POSE_W + 2 * DIM_W;

  typedef enum logic {
    REQ_P1 = 1'b0,
    REQ_P2 = 1'b1
  } req_idx_e;

  // ROM layout: pose selects a 64x64 page, y selects the row, x the column.
  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [POSE_W-1:0] pose,
    input logic [DIM_W-1:0]  y,
    input logic [DIM_W-1:0]  x
  );
    return {pose, y, x};
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer to use next.
module rr_arbiter2
  import sprite_rom_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_e   ptr_i,
  output logic [1:0] gnt_o,
  output req_idx_e   ptr_o
);

  always_comb begin
    gnt_o = '0;
    ptr_o = ptr_i;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (ptr_i == REQ_P1) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
    if (gnt_o[0]) begin
      ptr_o = REQ_P2;
    end else if (gnt_o[1]) begin
      ptr_o = REQ_P1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM between two players: round-robin grant, registered
// address, and a one-hot tag pipeline that routes returned data back.
module sprite_rom_arbiter #(
  parameter int unsigned POSE_W  = sprite_rom_arbiter_pkg::POSE_W,
  parameter int unsigned DIM_W   = sprite_rom_arbiter_pkg::DIM_W,
  parameter int unsigned DATA_W  = sprite_rom_arbiter_pkg::DATA_W,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [1:0]                req,
  input  logic [POSE_W-1:0]         pose0,
  input  logic [POSE_W-1:0]         pose1,
  input  logic [DIM_W-1:0]          x0,
  input  logic [DIM_W-1:0]          y0,
  input  logic [DIM_W-1:0]          x1,
  input  logic [DIM_W-1:0]          y1,
  output logic [1:0]                gnt,
  output logic [POSE_W+2*DIM_W-1:0] rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [1:0]                rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  import sprite_rom_arbiter_pkg::*;

  localparam int unsigned AW = POSE_W + 2 * DIM_W;

  req_idx_e          ptr_q, ptr_d;
  logic [1:0]        req_en;
  logic [AW-1:0]     addr0, addr1;
  logic [AW-1:0]     rom_address_q, rom_address_d;
  logic [1:0]        tag_q [ROM_LAT+1];
  logic [1:0]        rd_valid_q;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Gating with reset_n keeps gnt low the instant reset asserts.
  assign req_en = req & {2{enable & reset_n}};

  rr_arbiter2 u_rr_arbiter2 (
    .req_i (req_en),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .ptr_o (ptr_d)
  );

  // The package packer only matches the default widths; other sizes concatenate directly.
  if (POSE_W == sprite_rom_arbiter_pkg::POSE_W && DIM_W == sprite_rom_arbiter_pkg::DIM_W)
  begin : g_pkg_pack
    assign addr0 = sprite_addr(pose0, y0, x0);
    assign addr1 = sprite_addr(pose1, y1, x1);
  end else begin : g_raw_pack
    assign addr0 = {pose0, y0, x0};
    assign addr1 = {pose1, y1, x1};
  end

  always_comb begin
    rom_address_d = rom_address_q;
    if (gnt[0]) begin
      rom_address_d = addr0;
    end else if (gnt[1]) begin
      rom_address_d = addr1;
    end
    rd_data_d = rd_data_q;
    if (|tag_q[ROM_LAT]) begin
      rd_data_d = rom_q;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= REQ_P1;
      rom_address_q <= '0;
      rd_valid_q    <= '0;
      rd_data_q     <= '0;
      for (int unsigned i = 0; i <= ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      rom_address_q <= rom_address_d;
      tag_q[0]      <= gnt;
      for (int unsigned i = 1; i <= ROM_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      rd_valid_q    <= tag_q[ROM_LAT];
      rd_data_q     <= rd_data_d;
    end
  end

  assign rom_address = rom_address_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a one-cycle ROM model.
module tb_sprite_rom_arbiter;

  localparam int POSE_W  = 2;
  localparam int DIM_W   = 6;
  localparam int DATA_W  = 4;
  localparam int ROM_LAT = 1;
  localparam int AW      = POSE_W + 2 * DIM_W;

  logic              vga_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable  = 1'b0;
  logic [1:0]        req     = '0;
  logic [POSE_W-1:0] pose0 = '0, pose1 = '0;
  logic [DIM_W-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [1:0]        gnt, rd_valid;
  logic [AW-1:0]     rom_address;
  logic [DATA_W-1:0] rom_q, rd_data;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter #(
    .POSE_W  (POSE_W),
    .DIM_W   (DIM_W),
    .DATA_W  (DATA_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .req         (req),
    .pose0       (pose0),
    .pose1       (pose1),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  function automatic logic [DATA_W-1:0] rom_fn(input logic [AW-1:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {2'b00, a[13:12]} ^ 4'h9;
  endfunction

  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) rom_q <= '0;
    else          rom_q <= rom_fn(rom_address);
  end

  typedef struct {
    int                cyc_due;
    logic [1:0]        tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  logic              ptr_m   = 1'b0;
  logic [AW-1:0]     addr_m  = '0;
  logic [DATA_W-1:0] data_m  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] model_gnt(input logic [1:0] r, input logic en, input logic p);
    if (!en) return 2'b00;
    case (r)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return p ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check_outputs();
    exp_t e;
    check_eq("rom_address", rom_address, addr_m);
    if (sb.size() > 0 && sb[0].cyc_due == cyc) begin
      e = sb.pop_front();
      check_eq("rd_valid", rd_valid, e.tag);
      check_eq("rd_data", rd_data, e.data);
      data_m = e.data;
    end else begin
      check_eq("rd_valid_idle", rd_valid, 2'b00);
      check_eq("rd_data_hold", rd_data, data_m);
    end
  endtask

  // Entered and left 1 time unit after a rising edge.
  task automatic drive_cycle(input logic [1:0] r, input logic en, output logic [1:0] g_obs);
    logic [1:0]    g;
    logic [AW-1:0] a;
    req = r;
    enable = en;
    #2;
    g = model_gnt(r, en, ptr_m);
    g_obs = gnt;
    check_eq("gnt", gnt, g);
    if (g != 2'b00) begin
      a = g[0] ? {pose0, y0, x0} : {pose1, y1, x1};
      sb.push_back('{cyc + ROM_LAT + 2, g, rom_fn(a)});
      addr_m = a;
      ptr_m  = g[0];
    end
    @(posedge vga_clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset(input logic [1:0] r, input logic en);
    req = r;
    enable = en;
    reset_n = 1'b0;
    #1;
    check_eq("rst_gnt", gnt, 2'b00);
    check_eq("rst_rd_valid", rd_valid, 2'b00);
    check_eq("rst_rd_data", rd_data, '0);
    check_eq("rst_rom_address", rom_address, '0);
    sb.delete();
    ptr_m  = 1'b0;
    addr_m = '0;
    data_m = '0;
    @(posedge vga_clk);
    #1;
    cyc++;
    check_outputs();
    reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    logic [1:0] g;
    for (int i = 0; i < n; i++) drive_cycle(2'b00, 1'b1, g);
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

    do_reset(2'b11, 1'b1);

    // Single grant to player 1 and the fixed address it produces
    pose0 = 2'd2; x0 = 6'd5; y0 = 6'd3;
    drive_cycle(2'b01, 1'b1, g);
    check_eq("single_gnt", g, 2'b01);
    check_eq("addr_20C5", rom_address, 14'h20C5);
    idle(3);

    // Both requesting from reset: strict alternation, back-to-back returns
    do_reset(2'b00, 1'b1);
    pose1 = 2'd1; x1 = 6'd40; y1 = 6'd17;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(2'b11, 1'b1, g);
      check_eq("rr_seq", g, seq[i]);
    end
    idle(4);

    // Enable low blocks grants; first grant after raising it goes to player 1
    for (int i = 0; i < 3; i++) drive_cycle(2'b11, 1'b0, g);
    drive_cycle(2'b11, 1'b1, g);
    check_eq("enable_first", g, 2'b01);
    idle(3);

    // Reset right after a grant discards the in-flight read
    drive_cycle(2'b01, 1'b1, g);
    do_reset(2'b01, 1'b1);
    idle(3);
    drive_cycle(2'b11, 1'b1, g);
    check_eq("resume_gnt", g, 2'b01);
    idle(3);

    // Lone player 2 keeps winning; pointer ends back at player 1
    do_reset(2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b10, 1'b1, g);
      check_eq("p2_only", g, 2'b10);
    end
    drive_cycle(2'b11, 1'b1, g);
    check_eq("ptr_after_p2", g, 2'b01);
    idle(3);

    // Grant then drop req and enable: read still returns, address holds
    pose0 = 2'd3; x0 = 6'd63; y0 = 6'd62;
    drive_cycle(2'b01, 1'b1, g);
    for (int i = 0; i < 4; i++) drive_cycle(2'b00, 1'b0, g);
    check_eq("addr_hold", rom_address, 14'h3FBF);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      pose0 = POSE_W'($urandom); pose1 = POSE_W'($urandom);
      x0 = DIM_W'($urandom); y0 = DIM_W'($urandom);
      x1 = DIM_W'($urandom); y1 = DIM_W'($urandom);
      drive_cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), g);
    end
    idle(5);
    check_eq("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
